sb_mem_slave: RTL and testbench

//  Memory-side responder for the simple_bus handshake (req/gnt, addr/data/mode, start/rdy).

---
 rtl/sb_mem_slave.sv | 142 ++++++++++++++
 tb/tb_sb_mem_slave.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sb_mem_slave.sv
// Memory-side responder for the simple_bus req/gnt + start/rdy handshake.
// Owns a 2**ADDR_W x DATA_W array; answers read, write, read-increment or error.
module sb_mem_slave #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              gnt,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdy,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [1:0]        dbg_state
);

    // Handshake: gnt high means the master may pulse start for one cycle;
    // start is only honoured while granted and idle (GRANT), and rdy pulses
    // exactly once, LATENCY cycles later, with rdata/err valid in that cycle only.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [1:0] MODE_RD  = 2'b00;
    localparam logic [1:0] MODE_WR  = 2'b01;
    localparam logic [1:0] MODE_INC = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic [1:0]        cap_mode;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              accept;
    logic              commit;
    logic [ADDR_W-1:0] act_addr;
    logic [1:0]        act_mode;
    logic [DATA_W-1:0] act_wdata;
    logic [DATA_W-1:0] rd_word;

    assign dbg_state = state;

    // With LATENCY=1 the commit edge is the accept edge, so the live inputs
    // are used instead of the not-yet-captured copies.
    always_comb begin
        accept    = (state == GRANT) && start;
        commit    = (accept && (LATENCY == 1)) || ((state == BUSY) && (cnt == 4'd1));
        act_addr  = (state == GRANT) ? addr  : cap_addr;
        act_mode  = (state == GRANT) ? mode  : cap_mode;
        act_wdata = (state == GRANT) ? wdata : cap_wdata;
        rd_word   = mem[act_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            rdy       <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            cnt       <= 4'd0;
            cap_addr  <= '0;
            cap_mode  <= MODE_RD;
            cap_wdata <= '0;
        end else begin
            rdy   <= 1'b0;
            rdata <= '0;
            err   <= 1'b0;
            if (commit) begin
                rdy <= 1'b1;
                case (act_mode)
                    MODE_RD, MODE_INC: rdata <= rd_word;
                    MODE_ILL:          err   <= 1'b1;
                    default:           rdata <= '0;
                endcase
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        state <= GRANT;
                        gnt   <= 1'b1;
                    end
                end
                GRANT: begin
                    if (start) begin
                        cap_addr  <= addr;
                        cap_mode  <= mode;
                        cap_wdata <= wdata;
                        cnt       <= CNT_LOAD;
                        state     <= (LATENCY == 1) ? DONE : BUSY;
                    end else if (!req) begin
                        state <= IDLE;
                        gnt   <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (req) begin
                        state <= GRANT;
                    end else begin
                        state <= IDLE;
                        gnt   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 1'b0;
                end
            endcase
        end
    end

    // Array is never cleared; a reset on the commit edge suppresses the update.
    always_ff @(posedge clk) begin
        if (rst_n && commit) begin
            case (act_mode)
                MODE_WR:  mem[act_addr] <= act_wdata;
                MODE_INC: mem[act_addr] <= rd_word + DATA_W'(1);
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_mem_slave.sv
// Directed bench for sb_mem_slave: reset, grant timing, read/write/increment,
// illegal mode, ignored starts and reset during a transaction.
module tb_sb_mem_slave;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       gnt;
    logic       start;
    logic [7:0] addr;
    logic [1:0] mode;
    logic [7:0] wdata;
    logic       rdy;
    logic [7:0] rdata;
    logic       err;
    logic [1:0] dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    sb_mem_slave #(.ADDR_W(8), .DATA_W(8), .LATENCY(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .start     (start),
        .addr      (addr),
        .mode      (mode),
        .wdata     (wdata),
        .rdy       (rdy),
        .rdata     (rdata),
        .err       (err),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rdy"}, 32'(rdy), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Issues one transaction from GRANT and checks the 2-cycle rdy timing.
    task automatic txn(input string tag, input logic [1:0] m, input logic [7:0] a,
                       input logic [7:0] wd, input logic [7:0] exp_rdata, input logic exp_err);
        start = 1'b1;
        mode  = m;
        addr  = a;
        wdata = wd;
        tick();
        start = 1'b0;
        wdata = 8'h00;
        chk({tag, "_busy"}, 32'(rdy), 32'd0);
        tick();
        chk({tag, "_rdy"}, 32'(rdy), 32'd1);
        chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        tick();
        chk_quiet({tag, "_after"});
        chk({tag, "_gnt"}, 32'(gnt), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b1;
        start = 1'b0;
        addr  = 8'h00;
        mode  = 2'b00;
        wdata = 8'h00;

        // Reset held three cycles with req high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_gnt", 32'(gnt), 32'd0);
            chk_quiet("reset");
        end
        chk("reset_state", 32'(dbg_state), 32'd0);

        // Grant timing
        rst_n = 1'b1;
        req   = 1'b0;
        tick();
        chk("idle_gnt", 32'(gnt), 32'd0);
        req = 1'b1;
        tick();
        chk("grant_c1", 32'(gnt), 32'd1);
        tick();
        chk("grant_c2", 32'(gnt), 32'd1);
        tick();
        chk("grant_c3", 32'(gnt), 32'd1);
        req = 1'b0;
        tick();
        chk("grant_drop_c4", 32'(gnt), 32'd0);
        chk("grant_drop_state", 32'(dbg_state), 32'd0);
        req = 1'b1;
        tick();
        chk("regrant", 32'(gnt), 32'd1);

        // Write then read
        txn("wr_3c", 2'b01, 8'h3C, 8'hA5, 8'h00, 1'b0);
        txn("rd_3c", 2'b00, 8'h3C, 8'h00, 8'hA5, 1'b0);

        // Read-increment wrap
        txn("wr_10", 2'b01, 8'h10, 8'hFF, 8'h00, 1'b0);
        txn("inc1_10", 2'b10, 8'h10, 8'h00, 8'hFF, 1'b0);
        txn("inc2_10", 2'b10, 8'h10, 8'h00, 8'h00, 1'b0);
        txn("rd_10", 2'b00, 8'h10, 8'h00, 8'h01, 1'b0);

        // Illegal mode leaves the array untouched
        txn("wr_05", 2'b01, 8'h05, 8'h5A, 8'h00, 1'b0);
        txn("ill_05", 2'b11, 8'h05, 8'h99, 8'h00, 1'b1);
        txn("rd_05", 2'b00, 8'h05, 8'h00, 8'h5A, 1'b0);

        // Starts during BUSY and DONE are ignored
        start = 1'b1;
        mode  = 2'b00;
        addr  = 8'h3C;
        tick();
        chk("ign_busy_rdy", 32'(rdy), 32'd0);
        mode  = 2'b01;
        wdata = 8'h00;
        tick();
        chk("ign_done_rdy", 32'(rdy), 32'd1);
        chk("ign_done_rdata", 32'(rdata), 32'hA5);
        tick();
        start = 1'b0;
        chk_quiet("ign_after1");
        tick();
        chk_quiet("ign_after2");
        tick();
        chk_quiet("ign_after3");
        txn("ign_rd_3c", 2'b00, 8'h3C, 8'h00, 8'hA5, 1'b0);

        // Reset during BUSY discards the write
        txn("wr_20", 2'b01, 8'h20, 8'h11, 8'h00, 1'b0);
        start = 1'b1;
        mode  = 2'b01;
        addr  = 8'h20;
        wdata = 8'h77;
        tick();
        start = 1'b0;
        chk("rst_mid_busy", 32'(dbg_state), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_gnt", 32'(gnt), 32'd0);
        chk_quiet("rst_mid");
        tick();
        chk("rst_mid_regrant", 32'(gnt), 32'd1);
        chk("rst_mid_rdy2", 32'(rdy), 32'd0);
        tick();
        chk("rst_mid_rdy3", 32'(rdy), 32'd0);
        txn("rd_20", 2'b00, 8'h20, 8'h00, 8'h11, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
